// File: rtl/axi_rd_4k_splitter.sv
// AXI4 read master that turns one long read command into INCR bursts which never
// cross a 4 KB page, streaming the returned beats straight out with one burst in flight.
module axi_rd_4k_splitter #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int MAX_BEATS          = 256
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [19:0]                   cmd_beats,
  output logic [0:0]                    M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARLOCK,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARQOS,
  output logic [0:0]                    M_AXI_ARUSER,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] out_data,
  output logic                          out_last,
  output logic                          done,
  output logic                          err
);

  typedef enum logic [2:0] {IDLE, CALC, AR, RD, DONE} state_t;

  localparam logic [8:0] MAX_LEN = 9'(MAX_BEATS);

  state_t                          state, state_next;
  logic                            started;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr;
  logic [19:0]                     remaining;
  logic [8:0]                      len_beats;
  logic [8:0]                      len_calc;
  logic [8:0]                      page_room;
  logic [7:0]                      arlen;
  logic                            err_q;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARSIZE  = 3'b100;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARQOS   = '0;
  assign M_AXI_ARUSER  = '0;
  assign M_AXI_ARADDR  = araddr;
  assign M_AXI_ARLEN   = arlen;
  assign out_data      = M_AXI_RDATA;
  assign err           = err_q;

  // Beats left in the page: 256 - addr[11:4], kept 9 bits wide so a page-aligned
  // address yields a full 256 rather than wrapping to 0.
  always_comb begin
    page_room = 9'd256 - {1'b0, addr[11:4]};
    len_calc  = page_room;
    if (MAX_LEN < len_calc) len_calc = MAX_LEN;
    if (remaining < {11'd0, len_calc}) len_calc = remaining[8:0];
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = started;
        if (cmd_valid && started) state_next = CALC;
      end
      CALC: state_next = AR;
      AR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_next = RD;
      end
      RD: begin
        out_valid    = M_AXI_RVALID;
        M_AXI_RREADY = out_ready;
        out_last     = M_AXI_RLAST && (remaining == '0);
        if (M_AXI_RVALID && out_ready && M_AXI_RLAST)
          state_next = (remaining == '0) ? DONE : CALC;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // started holds cmd_ready low until the first clock after reset release.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      started   <= 1'b0;
      addr      <= '0;
      araddr    <= '0;
      remaining <= '0;
      len_beats <= '0;
      arlen     <= '0;
      err_q     <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_valid && started) begin
            addr      <= cmd_addr;
            remaining <= cmd_beats;
            err_q     <= 1'b0;
          end
        end
        CALC: begin
          len_beats <= len_calc;
          araddr    <= addr;
          arlen     <= 8'(len_calc - 9'd1);
        end
        AR: begin
          if (M_AXI_ARREADY) begin
            addr      <= addr + (C_M_AXI_ADDR_WIDTH'(len_beats) << 4);
            remaining <= remaining - 20'(len_beats);
          end
        end
        RD: begin
          if (M_AXI_RVALID && out_ready && (M_AXI_RRESP != 2'b00)) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_4k_splitter.sv
// Randomized bench for axi_rd_4k_splitter: a queue of expected bursts from page arithmetic,
// an in-bench AXI read slave, and a beat-index data pattern to catch loss/duplication.
module tb_axi_rd_4k_splitter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [31:0]  cmd_addr = '0;
  logic [19:0]  cmd_beats = '0;
  logic [0:0]   M_AXI_ARID;
  logic [31:0]  M_AXI_ARADDR;
  logic [7:0]   M_AXI_ARLEN;
  logic [2:0]   M_AXI_ARSIZE;
  logic [1:0]   M_AXI_ARBURST;
  logic         M_AXI_ARLOCK;
  logic [3:0]   M_AXI_ARCACHE;
  logic [2:0]   M_AXI_ARPROT;
  logic [3:0]   M_AXI_ARQOS;
  logic [0:0]   M_AXI_ARUSER;
  logic         M_AXI_ARVALID;
  logic         M_AXI_ARREADY = 1'b0;
  logic         M_AXI_RVALID = 1'b0;
  logic         M_AXI_RREADY;
  logic [127:0] M_AXI_RDATA = '0;
  logic [1:0]   M_AXI_RRESP = '0;
  logic         M_AXI_RLAST = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_last;
  logic         done;
  logic         err;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic        exp_err = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;
  ar_t exp_ar[$];

  always #5 clk = ~clk;

  axi_rd_4k_splitter #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(128),
    .MAX_BEATS(256)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
    .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
    .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .err(err)
  );

  function automatic logic [127:0] beat_data(input int unsigned idx);
    logic [31:0] w;
    w = idx * 32'h9E37_79B1 ^ 32'h5A5A_0000;
    return {w, ~w, idx, w + idx};
  endfunction

  // Burst plan straight from the page rule: take as many beats as remain, fit in the
  // current 4 KB page, and do not exceed 256.
  task automatic build_expected(input logic [31:0] a, input int unsigned beats);
    logic [31:0] pa;
    int unsigned rem, room, n;
    pa  = a;
    rem = beats;
    exp_ar.delete();
    while (rem > 0) begin
      room = (4096 - (pa % 4096)) / 16;
      n = rem;
      if (room < n) n = room;
      if (256 < n) n = 256;
      exp_ar.push_back('{pa, 8'(n - 1)});
      pa  = pa + n * 16;
      rem = rem - n;
    end
  endtask

  task automatic run_cmd(input logic [31:0] a, input int unsigned beats, input int unsigned ar_hold,
                         input int err_beat, input bit rnd_ready, input int abort_at);
    int unsigned beats_out, slave_left, slave_next, ar_wait, budget;
    bit rv_hold, done_due, done_seen, aborted, last_acc, err_next;
    build_expected(a, beats);
    beats_out = 0; slave_left = 0; ar_wait = 0; rv_hold = 0;
    done_due = 0; done_seen = 0; aborted = 0;
    budget = 20 * beats + 400;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_beats = 20'(beats);
    M_AXI_RVALID = 1'b0; M_AXI_ARREADY = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || err !== exp_err)
      $display("FAIL cmd_accept: cmd_ready=%b err=%b want 1 %b", cmd_ready, err, exp_err);
    else passed++;
    @(posedge clk);
    exp_err = 1'b0;

    for (int cyc = 0; cyc < int'(budget) && !done_seen && !aborted; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_beats = 20'($urandom);
      if (slave_left > 0) begin
        if (!rv_hold) rv_hold = ($urandom_range(0, 3) != 0);
        M_AXI_RVALID = rv_hold;
        M_AXI_RDATA  = beat_data(beats_out);
        M_AXI_RLAST  = (slave_left == 1);
        M_AXI_RRESP  = (int'(beats_out) == err_beat) ? 2'b10 : 2'b00;
      end else begin
        M_AXI_RVALID = 1'($urandom_range(0, 1));
        M_AXI_RDATA  = {$urandom, $urandom, $urandom, $urandom};
        M_AXI_RLAST  = 1'($urandom_range(0, 1));
        M_AXI_RRESP  = 2'($urandom_range(0, 3));
      end
      M_AXI_ARREADY = (ar_hold == 0) ? 1'($urandom_range(0, 1)) : (ar_wait >= ar_hold);
      out_ready     = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;

      if (abort_at >= 0 && int'(beats_out) == abort_at && slave_left > 0) begin
        rst_n = 1'b0;
        #1;
        total++;
        if ({M_AXI_ARVALID, M_AXI_RREADY, out_valid, out_last, done, err, cmd_ready} !== 7'b0)
          $display("FAIL abort_reset: outputs=%b want 0000000",
                   {M_AXI_ARVALID, M_AXI_RREADY, out_valid, out_last, done, err, cmd_ready});
        else passed++;
        aborted = 1'b1;
      end else begin
        slave_next = slave_left;
        last_acc   = 1'b0;
        err_next   = exp_err;

        total++;
        if (cmd_ready !== 1'b0 || done !== done_due || err !== exp_err)
          $display("FAIL busy_status: ready/done/err=%b%b%b want 0%b%b", cmd_ready, done, err, done_due, exp_err);
        else passed++;
        if (done === 1'b1 && done_due) done_seen = 1'b1;

        if (M_AXI_ARVALID === 1'b1) begin
          total++;
          if (slave_left != 0 || exp_ar.size() == 0)
            $display("FAIL ar_issue: outstanding=%0d planned_left=%0d want 0 >0", slave_left, exp_ar.size());
          else passed++;
          if (exp_ar.size() > 0) begin
            total++;
            if (M_AXI_ARADDR !== exp_ar[0].addr || M_AXI_ARLEN !== exp_ar[0].len)
              $display("FAIL ar_fields: addr=%h len=%0d want %h %0d", M_AXI_ARADDR, M_AXI_ARLEN,
                       exp_ar[0].addr, exp_ar[0].len);
            else passed++;
            if (M_AXI_ARREADY) begin
              slave_next = int'(exp_ar[0].len) + 1;
              void'(exp_ar.pop_front());
              ar_wait = 0;
            end else ar_wait++;
          end
        end

        total++;
        if (slave_left > 0) begin
          if (out_valid !== M_AXI_RVALID || M_AXI_RREADY !== out_ready)
            $display("FAIL passthru: out_valid=%b rready=%b want %b %b", out_valid, M_AXI_RREADY,
                     M_AXI_RVALID, out_ready);
          else passed++;
          if (M_AXI_RVALID && out_ready) begin
            total++;
            if (out_data !== beat_data(beats_out) || out_last !== (beats_out == beats - 1))
              $display("FAIL beat_%0d: data=%h last=%b want %h %b", beats_out, out_data, out_last,
                       beat_data(beats_out), (beats_out == beats - 1));
            else passed++;
            if (M_AXI_RRESP != 2'b00) err_next = 1'b1;
            beats_out++;
            slave_next = slave_left - 1;
            rv_hold = 1'b0;
            last_acc = (slave_left == 1) && (exp_ar.size() == 0);
          end
        end else begin
          if (out_valid !== 1'b0 || M_AXI_RREADY !== 1'b0)
            $display("FAIL stray_beat: out_valid=%b rready=%b want 0 0", out_valid, M_AXI_RREADY);
          else passed++;
        end

        @(posedge clk);
        slave_left = slave_next;
        exp_err    = err_next;
        done_due   = last_acc;
      end
    end

    if (aborted) begin
      @(negedge clk);
      M_AXI_RVALID = 1'b0; M_AXI_ARREADY = 1'b0; cmd_valid = 1'b0;
      rst_n = 1'b1;
      exp_err = 1'b0;
      exp_ar.delete();
      @(posedge clk);
    end else begin
      total++;
      if (!done_seen || beats_out != beats || exp_ar.size() != 0)
        $display("FAIL completion: done_seen=%b beats=%0d bursts_left=%0d want 1 %0d 0",
                 done_seen, beats_out, exp_ar.size(), beats);
      else passed++;
      @(negedge clk);
      cmd_valid = 1'b0; M_AXI_RVALID = 1'b0;
      #1;
      total++;
      if (done !== 1'b0 || cmd_ready !== 1'b1)
        $display("FAIL done_pulse: done=%b cmd_ready=%b want 0 1", done, cmd_ready);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b1; M_AXI_RVALID = 1'b1; M_AXI_ARREADY = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({M_AXI_ARVALID, M_AXI_RREADY, out_valid, out_last, done, err, cmd_ready} !== 7'b0)
      $display("FAIL reset_outputs: %b want 0000000",
               {M_AXI_ARVALID, M_AXI_RREADY, out_valid, out_last, done, err, cmd_ready});
    else passed++;
    total++;
    if ({M_AXI_ARID, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE, M_AXI_ARLOCK, M_AXI_ARPROT,
         M_AXI_ARQOS, M_AXI_ARUSER} !== {1'b0, 3'b100, 2'b01, 4'b0011, 1'b0, 3'b0, 4'b0, 1'b0})
      $display("FAIL ar_constants: id=%h size=%b burst=%b cache=%b want 0 100 01 0011",
               M_AXI_ARID, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1; cmd_valid = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_ARREADY = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b0) $display("FAIL ready_before_clock: %b want 0", cmd_ready);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL ready_after_clock: %b want 1", cmd_ready);
    else passed++;
  endtask

  task automatic test_page_cross();
    run_cmd(32'h0000_0FC0, 10, 0, -1, 1'b0, -1);
  endtask

  task automatic test_long_burst();
    run_cmd(32'h0000_2000, 300, 0, -1, 1'b1, -1);
  endtask

  task automatic test_ar_stall();
    run_cmd({4'h0, 24'($urandom), 4'h0}, $urandom_range(1, 600), 20, -1, 1'b1, -1);
  endtask

  task automatic test_error();
    run_cmd(32'h0000_0400, 8, 0, 2, 1'b1, -1);
    run_cmd(32'h0000_0800, 4, 0, -1, 1'b0, -1);
  endtask

  task automatic test_single();
    run_cmd(32'h0000_0FF0, 1, 0, -1, 1'b1, -1);
  endtask

  task automatic test_reset_mid();
    run_cmd(32'h0001_0000, 64, 0, -1, 1'b1, 20);
    run_cmd(32'h0001_0F80, 40, 0, -1, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_cmd({4'h0, 24'($urandom), 4'h0}, $urandom_range(1, 700), 0, -1, 1'b1, -1);
  endtask

  initial begin
    test_reset();
    test_page_cross();
    test_long_burst();
    test_ar_stall();
    test_error();
    test_single();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
